// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state encoding and small decode helpers
// for the sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-step shift-add multiplier / restoring divider on operand
// magnitudes; the signed correction is applied combinationally on the output.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   result
);

  // Upper W+1 bits: partial product / partial remainder; lower W bits:
  // multiplier being consumed / dividend shifting out as quotient shifts in.
  logic [2*WIDTH:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

    mul_sum   = p_q[0] ? (p_q[2*WIDTH:WIDTH] + {1'b0, m_q}) : p_q[2*WIDTH:WIDTH];
    div_shift = p_q[2*WIDTH-1:WIDTH-1];
    div_trial = {1'b0, div_shift} - {2'b00, m_q};

    p_d    = p_q;
    m_d    = m_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;

    if (load) begin
      // Dividend and multiplier both start in the low half.
      p_d    = {{(WIDTH+1){1'b0}}, is_div ? mag_a : mag_b};
      m_d    = is_div ? mag_b : mag_a;
      div_d  = is_div;
      neg_d  = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      rneg_d = is_signed && op_a[WIDTH-1];
    end else if (step) begin
      if (div_q) begin
        if (!div_trial[WIDTH+1]) begin
          p_d = {div_trial[WIDTH:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = {div_shift, p_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        p_d = {1'b0, mul_sum, p_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

  always_comb begin
    prod = p_q[2*WIDTH-1:0];
    quo  = neg_q  ? (~p_q[WIDTH-1:0] + 1'b1)       : p_q[WIDTH-1:0];
    rem  = rneg_q ? (~p_q[2*WIDTH-1:WIDTH] + 1'b1) : p_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      result = {rem, quo};
    end else begin
      result = neg_q ? (~prod + 1'b1) : prod;
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU: FSM, single-cycle datapath and result/flag registers;
// multiply and divide are delegated to the iterative unit.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               ovf_pend_q, ovf_pend_d;

  logic               accept;
  logic               zero_div;
  logic               md_load, md_step;
  logic [2*WIDTH-1:0] md_result;
  logic [WIDTH:0]     a_ext, b_ext, sum;
  logic [2*WIDTH-1:0] sc_result;
  logic               sc_ovf;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .load      (md_load),
    .step      (md_step),
    .is_div    (is_div_op(op)),
    .is_signed ((op == OP_MUL) || (op == OP_DIV)),
    .op_a      (in_a),
    .op_b      (in_b),
    .result    (md_result)
  );

  always_comb begin
    a_ext     = {in_a[WIDTH-1], in_a};
    b_ext     = {in_b[WIDTH-1], in_b};
    sum       = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_result = {{(WIDTH-1){sum[WIDTH]}}, sum};
        sc_ovf    = sum[WIDTH] ^ sum[WIDTH-1];
      end
      OP_AND:  sc_result = {{WIDTH{1'b0}}, in_a & in_b};
      OP_OR:   sc_result = {{WIDTH{1'b0}}, in_a | in_b};
      OP_XOR:  sc_result = {{WIDTH{1'b0}}, in_a ^ in_b};
      OP_SLT:  sc_result = {{(2*WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    md_load    = 1'b0;
    md_step    = 1'b0;
    accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    zero_div   = is_div_op(op) && (in_b == '0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (is_iter_op(op) && !zero_div) begin
            // Flags clear now; result keeps the previous value until completion.
            md_load    = 1'b1;
            cnt_d      = '0;
            dbz_d      = 1'b0;
            ovf_d      = 1'b0;
            ovf_pend_d = (op == OP_DIV) && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
            state_d    = ST_CALC;
          end else begin
            result_d = zero_div ? '0 : sc_result;
            dbz_d    = zero_div;
            ovf_d    = zero_div ? 1'b0 : sc_ovf;
            state_d  = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        md_step = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        result_d = md_result;
        ovf_d    = ovf_pend_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  assign busy        = (state_q == ST_CALC) || (state_q == ST_CORR);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param at WIDTH=8: directed vector table, hand-written
// corner sequences, and random ops checked against an arithmetic model.
module tb_alu_seq_param;
  import alu_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   in_a, in_b;
  logic           busy, done, div_by_zero, overflow;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .in_a        (in_a),
    .in_b        (in_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           dbz;
    logic           ovf;
    int             lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference computed with plain integer arithmetic on the operand values.
  function automatic vec_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t   v;
    longint sa, sb, ua, ub, s, q, r;
    logic [W-1:0] qb, rb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    v.op = o; v.a = a; v.b = b;
    v.res = '0; v.dbz = 1'b0; v.ovf = 1'b0; v.lat = 1;
    case (o)
      OP_ADD, OP_SUB: begin
        s = (o == OP_ADD) ? sa + sb : sa - sb;
        v.res = (2*W)'(s);
        v.ovf = (s > (longint'(1) <<< (W-1)) - 1) || (s < -(longint'(1) <<< (W-1)));
      end
      OP_MUL:  begin v.res = (2*W)'(sa * sb); v.lat = W + 2; end
      OP_MULU: begin v.res = (2*W)'(ua * ub); v.lat = W + 2; end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          v.dbz = 1'b1;
        end else begin
          if (o == OP_DIV) begin
            q = sa / sb; r = sa % sb;
            v.ovf = (sa == -(longint'(1) <<< (W-1))) && (sb == -1);
          end else begin
            q = ua / ub; r = ua % ub;
          end
          qb = W'(q); rb = W'(r);
          v.res = {rb, qb};
          v.lat = W + 2;
        end
      end
      OP_AND: v.res = (2*W)'(ua & ub);
      OP_OR:  v.res = (2*W)'(ua | ub);
      OP_XOR: v.res = (2*W)'(ua ^ ub);
      OP_SLT: v.res = (sa < sb) ? 1 : 0;
      default: v.res = '0;
    endcase
    return v;
  endfunction

  // Called #1 after a rising edge; returns with the DUT sitting in DONE.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] r, output logic dz, output logic ov,
                       output int lat, output int bcnt);
    op = o; in_a = a; in_b = b; start = 1'b1;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = result; dz = div_by_zero; ov = overflow;
    $display("op=%0d a=%h b=%h -> result=%h dbz=%b ovf=%b latency=%0d", o, a, b, r, dz, ov, lat);
  endtask

  logic [2*W-1:0] r_act;
  logic           dz_act, ov_act;
  int             lat_act, busy_act;
  vec_t           ev;

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0;
    vecs.push_back('{OP_MUL,  8'hF6, 8'h05, 16'hFFCE, 1'b0, 1'b0, 10});
    vecs.push_back('{OP_DIV,  8'hF9, 8'h02, 16'hFFFD, 1'b0, 1'b0, 10});
    vecs.push_back('{OP_DIV,  8'h64, 8'h04, 16'h0019, 1'b0, 1'b0, 10});
    vecs.push_back('{OP_DIV,  8'h0A, 8'h00, 16'h0000, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_ADD,  8'h19, 8'h11, 16'h002A, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_ADD,  8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_DIV,  8'h80, 8'hFF, 16'h0080, 1'b0, 1'b1, 10});
    vecs.push_back('{OP_SUB,  8'h80, 8'h01, 16'hFF7F, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_MULU, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 10});
    vecs.push_back('{OP_DIVU, 8'hFF, 8'h10, 16'h0F0F, 1'b0, 1'b0, 10});
    vecs.push_back('{OP_DIVU, 8'h05, 8'h00, 16'h0000, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SLT,  8'h80, 8'h01, 16'h0001, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_XOR,  8'hF0, 8'h3C, 16'h00CC, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12,   8'h55, 8'h22, 16'h0000, 1'b0, 1'b0, 1});

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);

    // First start issued together with reset release.
    reset = 1'b0;
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r_act, dz_act, ov_act, lat_act, busy_act);
      check($sformatf("vec%0d_result", i), 64'(r_act), 64'(vecs[i].res));
      check($sformatf("vec%0d_dbz", i), 64'(dz_act), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_ovf", i), 64'(ov_act), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_latency", i), 64'(lat_act), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_act), 64'(vecs[i].lat - 1));
    end

    // Div-by-zero flag and result persist past the done pulse.
    do_op(OP_DIV, 8'h0A, 8'h00, r_act, dz_act, ov_act, lat_act, busy_act);
    @(posedge clk); #1;
    check("sticky_done_low", 64'(done), 64'd0);
    check("sticky_dbz", 64'(div_by_zero), 64'd1);
    do_op(OP_ADD, 8'd25, 8'd17, r_act, dz_act, ov_act, lat_act, busy_act);
    @(posedge clk); #1;
    check("held_result", 64'(result), 64'h002A);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);

    // start and operand changes during MUL iteration must be ignored.
    op = OP_MUL; in_a = 8'hF6; in_b = 8'h05; start = 1'b1;
    lat_act = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 3) begin
        start = 1'b1; op = OP_ADD; in_a = 8'h11; in_b = 8'h22;
      end
      if (done) begin
        lat_act = k;
        break;
      end
    end
    start = 1'b0;
    $display("op=%0d a=f6 b=05 (start pulsed mid-calc) -> result=%h latency=%0d", OP_MUL, result, lat_act);
    check("ignored_start_result", 64'(result), 64'hFFCE);
    check("ignored_start_latency", 64'(lat_act), 64'd10);

    // Reset asserted asynchronously in the middle of a DIV.
    @(posedge clk); #1;
    op = OP_DIV; in_a = 8'h64; in_b = 8'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
    lat_act = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) lat_act++;
    end
    check("abort_no_done", 64'(lat_act), 64'd0);
    reset = 1'b0;
    do_op(OP_ADD, 8'd25, 8'd17, r_act, dz_act, ov_act, lat_act, busy_act);
    check("post_abort_result", 64'(r_act), 64'h002A);
    check("post_abort_latency", 64'(lat_act), 64'd1);

    // Random ops against the model, biased toward zero divisors and MIN/-1.
    for (int n = 0; n < 300; n++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 19) == 0) begin ra = 8'h80; rb = 8'hFF; end
      ev = model(ro, ra, rb);
      do_op(ro, ra, rb, r_act, dz_act, ov_act, lat_act, busy_act);
      check($sformatf("rnd%0d_result", n), 64'(r_act), 64'(ev.res));
      check($sformatf("rnd%0d_dbz", n), 64'(dz_act), 64'(ev.dbz));
      check($sformatf("rnd%0d_ovf", n), 64'(ov_act), 64'(ev.ovf));
      check($sformatf("rnd%0d_latency", n), 64'(lat_act), 64'(ev.lat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
